rst_seq: RTL and testbench

Staged reset-release sequencer that consumes the synchronized active-high reset `rst_main` from the reset synchronizer and drives the per-domain block resets. All stage resets assert together and hold for a minimum time. The block then waits for a stable PLL lock and releases the stages one at a time, in order, with a fixed gap between releases. A software reset request or a loss of lock re-runs the full sequence.

---
 rtl/rst_seq.sv | 158 +++++++++++++++
 tb/tb_rst_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// Staged reset-release sequencer: holds all stage resets, waits for a stable PLL
// lock, then releases stages in ascending order with a fixed gap between them.
//
// state     | meaning
// ASSERT    | all stage resets asserted, counting the hold time
// WAIT_LOCK | hold complete, counting consecutive synchronized lock cycles
// RELEASE   | releasing one stage every GAP_CYC cycles
// RUN       | all stages released, outputs static

module rst_seq #(
  parameter int N_STAGE  = 3,
  parameter int HOLD_CYC = 16,
  parameter int LOCK_CYC = 8,
  parameter int GAP_CYC  = 4
) (
  input  logic               clk,
  input  logic               rst_main,
  input  logic               pll_lock,
  input  logic               sw_rst_req,
  output logic [N_STAGE-1:0] rst_out,
  output logic               rst_done,
  output logic [1:0]         seq_state,
  output logic [1:0]         rst_cause
);

  localparam int CNT_MAX_HL = (HOLD_CYC > LOCK_CYC) ? HOLD_CYC : LOCK_CYC;
  localparam int CNT_MAX    = (CNT_MAX_HL > GAP_CYC) ? CNT_MAX_HL : GAP_CYC;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int K_W        = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYC - 1);

  localparam logic [1:0] CAUSE_MAIN = 2'd0;
  localparam logic [1:0] CAUSE_SW   = 2'd1;
  localparam logic [1:0] CAUSE_LOCK = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [K_W-1:0]     k_q,         k_d;
  logic [N_STAGE-1:0] rst_out_q,   rst_out_d;
  logic               rst_done_q,  rst_done_d;
  logic [1:0]         rst_cause_q, rst_cause_d;
  logic               lock_meta_q, lock_meta_d;
  logic               lock_s_q,    lock_s_d;
  logic               lock_lost;

  always_comb begin
    lock_meta_d = pll_lock;
    lock_s_d    = lock_meta_q;
    lock_lost   = !lock_s_q && (state_q == ST_RELEASE || state_q == ST_RUN);

    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    rst_out_d   = rst_out_q;
    rst_done_d  = rst_done_q;
    rst_cause_d = rst_cause_q;

    if (sw_rst_req || lock_lost) begin
      state_d    = ST_ASSERT;
      cnt_d      = '0;
      k_d        = '0;
      rst_out_d  = '1;
      rst_done_d = 1'b0;
      // A request while already holding only restarts the hold; the cause is kept.
      if (sw_rst_req) begin
        if (state_q != ST_ASSERT) rst_cause_d = CAUSE_SW;
      end else begin
        rst_cause_d = CAUSE_LOCK;
      end
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == HOLD_TC) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q != LOCK_TC) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            k_d          = '0;
            if (N_STAGE == 1) begin
              state_d    = ST_RUN;
              rst_done_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_q == GAP_TC) begin
            for (int i = 0; i < N_STAGE; i++) begin
              if (i == int'(k_q) + 1) rst_out_d[i] = 1'b0;
            end
            k_d   = k_q + 1'b1;
            cnt_d = '0;
            if (int'(k_q) + 1 == N_STAGE - 1) begin
              state_d    = ST_RUN;
              rst_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_main) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      k_q         <= '0;
      rst_out_q   <= '1;
      rst_done_q  <= 1'b0;
      rst_cause_q <= CAUSE_MAIN;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      rst_out_q   <= rst_out_d;
      rst_done_q  <= rst_done_d;
      rst_cause_q <= rst_cause_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_done  = rst_done_q;
  assign seq_state = state_q;
  assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with default parameters; each task checks one scenario
// against hand-derived edge numbers (edge 0 = last edge sampling the reset event).

module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst_main;
  logic       pll_lock;
  logic       sw_rst_req;
  logic [2:0] rst_out;
  logic       rst_done;
  logic [1:0] seq_state;
  logic [1:0] rst_cause;

  int n_vec = 0;
  int n_err = 0;
  int e = 0;

  always #5 clk = ~clk;

  rst_seq #(
    .N_STAGE (3),
    .HOLD_CYC(16),
    .LOCK_CYC(8),
    .GAP_CYC (4)
  ) dut (
    .clk       (clk),
    .rst_main  (rst_main),
    .pll_lock  (pll_lock),
    .sw_rst_req(sw_rst_req),
    .rst_out   (rst_out),
    .rst_done  (rst_done),
    .seq_state (seq_state),
    .rst_cause (rst_cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    e = e + 1;
  endtask

  task automatic pulse_main(input logic lock);
    rst_main   = 1'b1;
    sw_rst_req = 1'b0;
    pll_lock   = lock;
    repeat (3) tick();
    rst_main = 1'b0;
    e = 0;
  endtask

  task automatic test_reset();
    rst_main   = 1'b1;
    sw_rst_req = 1'b0;
    pll_lock   = 1'b1;
    repeat (5) tick();
    n_vec++; if (rst_out !== 3'b111) begin $display("FAIL reset_out got=%b exp=111", rst_out); n_err++; end
    n_vec++; if (rst_done !== 1'b0) begin $display("FAIL reset_done got=%b exp=0", rst_done); n_err++; end
    n_vec++; if (seq_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", seq_state); n_err++; end
    n_vec++; if (rst_cause !== 2'd0) begin $display("FAIL reset_cause got=%0d exp=0", rst_cause); n_err++; end
    rst_main = 1'b0;
    e = 0;
  endtask

  task automatic test_power_on();
    logic [2:0] exp_out;
    logic [1:0] exp_st;
    for (int i = 1; i <= 34; i++) begin
      tick();
      exp_out = (e >= 32) ? 3'b000 : (e >= 28) ? 3'b100 : (e >= 24) ? 3'b110 : 3'b111;
      exp_st  = (e >= 32) ? 2'd3 : (e >= 24) ? 2'd2 : (e >= 16) ? 2'd1 : 2'd0;
      n_vec++; if (rst_out !== exp_out) begin $display("FAIL po_out e=%0d got=%b exp=%b", e, rst_out, exp_out); n_err++; end
      n_vec++; if (seq_state !== exp_st) begin $display("FAIL po_state e=%0d got=%0d exp=%0d", e, seq_state, exp_st); n_err++; end
      n_vec++; if (rst_done !== (e >= 32)) begin $display("FAIL po_done e=%0d got=%b exp=%b", e, rst_done, (e >= 32)); n_err++; end
      n_vec++; if (rst_cause !== 2'd0) begin $display("FAIL po_cause e=%0d got=%0d exp=0", e, rst_cause); n_err++; end
    end
  endtask

  task automatic test_lock_late();
    logic [2:0] exp_out;
    logic [1:0] exp_st;
    pulse_main(1'b0);
    for (int i = 1; i <= 49; i++) begin
      tick();
      if (e == 29) pll_lock = 1'b1;
      exp_out = (e >= 47) ? 3'b000 : (e >= 43) ? 3'b100 : (e >= 39) ? 3'b110 : 3'b111;
      exp_st  = (e >= 47) ? 2'd3 : (e >= 39) ? 2'd2 : (e >= 16) ? 2'd1 : 2'd0;
      n_vec++; if (rst_out !== exp_out) begin $display("FAIL late_out e=%0d got=%b exp=%b", e, rst_out, exp_out); n_err++; end
      n_vec++; if (seq_state !== exp_st) begin $display("FAIL late_state e=%0d got=%0d exp=%0d", e, seq_state, exp_st); n_err++; end
      n_vec++; if (rst_done !== (e >= 47)) begin $display("FAIL late_done e=%0d got=%b exp=%b", e, rst_done, (e >= 47)); n_err++; end
    end
  endtask

  task automatic test_lock_glitch();
    logic [2:0] exp_out;
    logic [1:0] exp_st;
    pulse_main(1'b1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (e == 19) pll_lock = 1'b0;
      if (e == 20) pll_lock = 1'b1;
      exp_out = (e >= 38) ? 3'b000 : (e >= 34) ? 3'b100 : (e >= 30) ? 3'b110 : 3'b111;
      exp_st  = (e >= 38) ? 2'd3 : (e >= 30) ? 2'd2 : (e >= 16) ? 2'd1 : 2'd0;
      n_vec++; if (rst_out !== exp_out) begin $display("FAIL glitch_out e=%0d got=%b exp=%b", e, rst_out, exp_out); n_err++; end
      n_vec++; if (seq_state !== exp_st) begin $display("FAIL glitch_state e=%0d got=%0d exp=%0d", e, seq_state, exp_st); n_err++; end
      n_vec++; if (rst_cause !== 2'd0) begin $display("FAIL glitch_cause e=%0d got=%0d exp=0", e, rst_cause); n_err++; end
    end
  endtask

  task automatic test_sw_reset_run();
    logic [2:0] exp_out;
    logic [1:0] exp_st;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    e = 0;
    n_vec++; if (rst_out !== 3'b111) begin $display("FAIL sw_out got=%b exp=111", rst_out); n_err++; end
    n_vec++; if (rst_done !== 1'b0) begin $display("FAIL sw_done got=%b exp=0", rst_done); n_err++; end
    n_vec++; if (seq_state !== 2'd0) begin $display("FAIL sw_state got=%0d exp=0", seq_state); n_err++; end
    n_vec++; if (rst_cause !== 2'd1) begin $display("FAIL sw_cause got=%0d exp=1", rst_cause); n_err++; end
    for (int i = 1; i <= 33; i++) begin
      tick();
      exp_out = (e >= 32) ? 3'b000 : (e >= 28) ? 3'b100 : (e >= 24) ? 3'b110 : 3'b111;
      exp_st  = (e >= 32) ? 2'd3 : (e >= 24) ? 2'd2 : (e >= 16) ? 2'd1 : 2'd0;
      n_vec++; if (rst_out !== exp_out) begin $display("FAIL swseq_out e=%0d got=%b exp=%b", e, rst_out, exp_out); n_err++; end
      n_vec++; if (seq_state !== exp_st) begin $display("FAIL swseq_state e=%0d got=%0d exp=%0d", e, seq_state, exp_st); n_err++; end
      n_vec++; if (rst_cause !== 2'd1) begin $display("FAIL swseq_cause e=%0d got=%0d exp=1", e, rst_cause); n_err++; end
    end
  endtask

  task automatic test_main_vs_sw();
    rst_main   = 1'b1;
    sw_rst_req = 1'b1;
    tick();
    rst_main   = 1'b0;
    sw_rst_req = 1'b0;
    e = 0;
    n_vec++; if (rst_out !== 3'b111) begin $display("FAIL mvs_out got=%b exp=111", rst_out); n_err++; end
    n_vec++; if (rst_done !== 1'b0) begin $display("FAIL mvs_done got=%b exp=0", rst_done); n_err++; end
    n_vec++; if (seq_state !== 2'd0) begin $display("FAIL mvs_state got=%0d exp=0", seq_state); n_err++; end
    n_vec++; if (rst_cause !== 2'd0) begin $display("FAIL mvs_cause got=%0d exp=0", rst_cause); n_err++; end
  endtask

  task automatic test_lock_loss_release();
    logic [2:0] exp_out;
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_out = (e >= 24) ? 3'b110 : 3'b111;
      n_vec++; if (rst_out !== exp_out) begin $display("FAIL ll_out e=%0d got=%b exp=%b", e, rst_out, exp_out); n_err++; end
    end
    pll_lock = 1'b0;
    tick();
    tick();
    n_vec++; if (rst_out !== 3'b110) begin $display("FAIL ll_pre_out e=%0d got=%b exp=110", e, rst_out); n_err++; end
    n_vec++; if (seq_state !== 2'd2) begin $display("FAIL ll_pre_state e=%0d got=%0d exp=2", e, seq_state); n_err++; end
    tick();
    n_vec++; if (rst_out !== 3'b111) begin $display("FAIL ll_post_out e=%0d got=%b exp=111", e, rst_out); n_err++; end
    n_vec++; if (seq_state !== 2'd0) begin $display("FAIL ll_post_state e=%0d got=%0d exp=0", e, seq_state); n_err++; end
    n_vec++; if (rst_cause !== 2'd2) begin $display("FAIL ll_post_cause e=%0d got=%0d exp=2", e, rst_cause); n_err++; end
    n_vec++; if (rst_done !== 1'b0) begin $display("FAIL ll_post_done e=%0d got=%b exp=0", e, rst_done); n_err++; end
  endtask

  task automatic test_sw_in_assert();
    logic [2:0] exp_out;
    logic [1:0] exp_st;
    pll_lock   = 1'b1;
    sw_rst_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++; if (seq_state !== 2'd0) begin $display("FAIL swa_state i=%0d got=%0d exp=0", i, seq_state); n_err++; end
      n_vec++; if (rst_cause !== 2'd2) begin $display("FAIL swa_cause i=%0d got=%0d exp=2", i, rst_cause); n_err++; end
    end
    sw_rst_req = 1'b0;
    e = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      exp_out = (e >= 24) ? 3'b110 : 3'b111;
      exp_st  = (e >= 24) ? 2'd2 : (e >= 16) ? 2'd1 : 2'd0;
      n_vec++; if (rst_out !== exp_out) begin $display("FAIL swa_out e=%0d got=%b exp=%b", e, rst_out, exp_out); n_err++; end
      n_vec++; if (seq_state !== exp_st) begin $display("FAIL swa_seq e=%0d got=%0d exp=%0d", e, seq_state, exp_st); n_err++; end
    end
  endtask

  task automatic test_sw_in_wait();
    pulse_main(1'b0);
    repeat (20) tick();
    n_vec++; if (seq_state !== 2'd1) begin $display("FAIL sww_pre_state got=%0d exp=1", seq_state); n_err++; end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_vec++; if (seq_state !== 2'd0) begin $display("FAIL sww_state got=%0d exp=0", seq_state); n_err++; end
    n_vec++; if (rst_cause !== 2'd1) begin $display("FAIL sww_cause got=%0d exp=1", rst_cause); n_err++; end
    n_vec++; if (rst_out !== 3'b111) begin $display("FAIL sww_out got=%b exp=111", rst_out); n_err++; end
  endtask

  initial begin
    rst_main   = 1'b1;
    pll_lock   = 1'b0;
    sw_rst_req = 1'b0;
    test_reset();
    test_power_on();
    test_lock_late();
    test_lock_glitch();
    test_sw_reset_run();
    test_main_vs_sw();
    test_lock_loss_release();
    test_sw_in_assert();
    test_sw_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
